// File: rtl/fifo_stream_reader_pkg.sv
// Shared FIFO read-side constants used by the stream reader and its skid buffer.
package fifo_stream_reader_pkg;

  localparam int SKID_DEPTH         = 2;
  localparam int FIFO_READ_LATENCY  = 1;
  localparam int FIFO_WIDTH_DEFAULT = 8;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_skid_buffer.sv
// Two-entry ordered buffer. Entry 0 is always the head; the caller owns flow control.
module stream_skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int EntryWidth = FIFO_WIDTH_DEFAULT + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [EntryWidth-1:0] push_data_i,
  output logic [EntryWidth-1:0] head_o,
  output occ_t                  occ_o
);

  logic [EntryWidth-1:0] e0_q, e0_d, e1_q, e1_d;
  occ_t                  occ_q, occ_d;

  // Entry shuffle: a simultaneous push and pop keeps occupancy and order.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) begin
          e0_d = push_data_i;
        end else begin
          e1_d = push_data_i;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data_i;
        end else begin
          e0_d = push_data_i;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign head_o = e0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read engine for a standard-mode FIFO: credit-limited Read issue, capture on Valid,
// packet framing, handshake statistics and a sticky overrun flag.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int Width       = FIFO_WIDTH_DEFAULT,
  parameter int PktLenWidth = 8,
  parameter int CountWidth  = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic [PktLenWidth-1:0] PktLen,
  input  logic                   FifoEmpty,
  output logic                   FifoRead,
  input  logic [Width-1:0]       FifoDout,
  input  logic                   FifoValid,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [Width-1:0]       OutData,
  output logic                   OutLast,
  output logic                   Busy,
  output logic [CountWidth-1:0]  WordCount,
  output logic                   Overrun
);

  occ_t             occ;
  logic [Width:0]   head;
  logic             pop, push, accept, stray, no_room, push_last;
  logic [2:0]       credit;

  logic                   in_flight_q, post_reset_q, overrun_q, overrun_d;
  logic [PktLenWidth-1:0] pkt_cnt_q, pkt_cnt_d, pkt_len_q, pkt_len_d, len_eff;
  logic [CountWidth-1:0]  word_count_q, word_count_d;

  assign OutValid = (occ != 2'd0);
  assign pop      = OutValid & OutReady;

  // A pop this cycle frees a slot, which keeps the read stream at one word per clock.
  assign credit   = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, pop};
  assign FifoRead = Enable & ~FifoEmpty & ~Reset & (credit < 3'(SKID_DEPTH));

  assign accept  = FifoValid & ~post_reset_q;
  assign stray   = accept & ~in_flight_q;
  assign no_room = accept & in_flight_q & (occ == 2'd2) & ~pop;
  assign push    = accept & in_flight_q & ~no_room;

  // Packet framing, statistics and error next-state.
  always_comb begin
    len_eff   = (pkt_cnt_q == '0) ? PktLen : pkt_len_q;
    push_last = (len_eff != '0) && (pkt_cnt_q == (len_eff - PktLenWidth'(1)));
    pkt_len_d = pkt_len_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) begin
      pkt_len_d = len_eff;
      if (push_last || (len_eff == '0)) begin
        pkt_cnt_d = '0;
      end else begin
        pkt_cnt_d = pkt_cnt_q + PktLenWidth'(1);
      end
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    if (pop) begin
      word_count_d = word_count_q + CountWidth'(1);
    end else begin
      word_count_d = word_count_q;
    end
    overrun_d = overrun_q | stray | no_room;
  end

  // Control and statistics registers; post_reset_q masks a stale Valid after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_flight_q  <= 1'b0;
      post_reset_q <= 1'b1;
      overrun_q    <= 1'b0;
      pkt_cnt_q    <= '0;
      pkt_len_q    <= '0;
      word_count_q <= '0;
    end else begin
      in_flight_q  <= FifoRead;
      post_reset_q <= 1'b0;
      overrun_q    <= overrun_d;
      pkt_cnt_q    <= pkt_cnt_d;
      pkt_len_q    <= pkt_len_d;
      word_count_q <= word_count_d;
    end
  end

  stream_skid_buffer #(
    .EntryWidth (Width + 1)
  ) u_skid (
    .clk_i       (Clk),
    .reset_i     (Reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i ({push_last, FifoDout}),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign OutData   = head[Width-1:0];
  assign OutLast   = OutValid & head[Width];
  assign Busy      = (occ != 2'd0) | in_flight_q;
  assign WordCount = word_count_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural standard-mode FIFO model feeding fifo_stream_reader.
module tb_fifo_stream_reader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [7:0]  PktLen = 8'd0;
  logic        FifoEmpty, FifoRead, FifoValid;
  logic [7:0]  FifoDout;
  logic        OutValid, OutLast, Busy, Overrun;
  logic        OutReady = 1'b1;
  logic [7:0]  OutData;
  logic [15:0] WordCount;

  int checks = 0;
  int failures = 0;

  // FIFO model
  logic [7:0] mem [0:63];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic [7:0] fifo_dout = 8'd0;
  logic       fifo_valid_m = 1'b0;
  logic       fifo_full, fifo_empty;
  logic       inj_valid = 1'b0;
  logic [7:0] inj_data = 8'd0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) >= 64);
  assign FifoEmpty  = fifo_empty;
  assign FifoValid  = fifo_valid_m | inj_valid;
  assign FifoDout   = inj_valid ? inj_data : fifo_dout;

  // Monitors
  int         cyc = 0;
  int         rwe = 0;
  int         xcnt = 0;
  int         rd_cyc[$];
  int         val_cyc[$];
  int         hs_cyc[$];
  logic [7:0] got_data[$];
  logic       got_last[$];

  fifo_stream_reader dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .PktLen(PktLen),
    .FifoEmpty(FifoEmpty), .FifoRead(FifoRead), .FifoDout(FifoDout), .FifoValid(FifoValid),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutLast(OutLast),
    .Busy(Busy), .WordCount(WordCount), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (FifoRead && !fifo_empty) begin
      fifo_dout    <= mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
      fifo_valid_m <= 1'b1;
    end else begin
      fifo_valid_m <= 1'b0;
    end
  end

  always @(posedge Clk) begin
    if (FifoRead) begin
      rd_cyc.push_back(cyc);
      if (fifo_empty) rwe++;
    end
    if (FifoValid) val_cyc.push_back(cyc);
    if (!Reset && OutValid && OutReady) begin
      got_data.push_back(OutData);
      got_last.push_back(OutLast);
      hs_cyc.push_back(cyc);
    end
    if ($isunknown({fifo_full, fifo_empty})) xcnt++;
    cyc++;
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset  = 1'b1;
    wr_ptr = rd_ptr;
    @(negedge Clk);
    Reset  = 1'b0;
  endtask

  task automatic preload(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = first + 8'(i);
      wr_ptr++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    checks++; if (OutValid !== 1'b0)   begin failures++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
    checks++; if (OutLast !== 1'b0)    begin failures++; $display("FAIL reset_outlast got=%b exp=0", OutLast); end
    checks++; if (OutData !== 8'h00)   begin failures++; $display("FAIL reset_outdata got=%h exp=00", OutData); end
    checks++; if (Busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (WordCount !== 16'd0) begin failures++; $display("FAIL reset_wordcount got=%0d exp=0", WordCount); end
    checks++; if (Overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", Overrun); end
  endtask

  task automatic test_basic();
    int br, bv, bh;
    OutReady = 1'b1; PktLen = 8'd0; Enable = 1'b1;
    do_reset();
    br = rd_cyc.size(); bv = val_cyc.size(); bh = got_data.size();
    preload(8'h11, 5);
    repeat (12) @(negedge Clk);
    checks++; if (rd_cyc.size() - br !== 5) begin failures++; $display("FAIL basic_reads got=%0d exp=5", rd_cyc.size() - br); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (rd_cyc.size() - br != 5 || rd_cyc[br+i] !== rd_cyc[br] + i) begin
        failures++; $display("FAIL basic_read_consecutive idx=%0d", i);
      end
    end
    checks++; if (got_data.size() - bh !== 5) begin failures++; $display("FAIL basic_words got=%0d exp=5", got_data.size() - bh); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_data.size() - bh != 5 || got_data[bh+i] !== 8'h11 + 8'(i) || got_last[bh+i] !== 1'b0 ||
          hs_cyc[bh+i] !== val_cyc[bv+i] + 1) begin
        failures++; $display("FAIL basic_word idx=%0d exp_data=%h", i, 8'h11 + 8'(i));
      end
    end
    checks++; if (WordCount !== 16'd5) begin failures++; $display("FAIL basic_wordcount got=%0d exp=5", WordCount); end
    checks++; if (Busy !== 1'b0)       begin failures++; $display("FAIL basic_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_packet(input bit change_len);
    int bh, t;
    logic [5:0] exp_last;
    exp_last = change_len ? 6'b000100 : 6'b100100;
    OutReady = 1'b1; PktLen = 8'd3; Enable = 1'b1;
    do_reset();
    bh = got_data.size();
    preload(8'h21, 6);
    if (change_len) begin
      t = 0;
      while (got_data.size() - bh < 1 && t < 20) begin @(negedge Clk); t++; end
      checks++; if (t >= 20) begin failures++; $display("FAIL packet_first_word_timeout"); end
      PktLen = 8'd5;
    end
    repeat (14) @(negedge Clk);
    checks++; if (got_data.size() - bh !== 6) begin failures++; $display("FAIL packet_words got=%0d exp=6", got_data.size() - bh); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_data.size() - bh != 6 || got_data[bh+i] !== 8'h21 + 8'(i) || got_last[bh+i] !== exp_last[i]) begin
        failures++; $display("FAIL packet_last chg=%0d idx=%0d exp_last=%b", change_len, i, exp_last[i]);
      end
    end
  endtask

  task automatic test_stall();
    int br, bh;
    OutReady = 1'b0; PktLen = 8'd0; Enable = 1'b1;
    do_reset();
    br = rd_cyc.size(); bh = got_data.size();
    preload(8'h31, 8);
    repeat (10) @(negedge Clk);
    checks++; if (rd_cyc.size() - br !== 2) begin failures++; $display("FAIL stall_reads got=%0d exp=2", rd_cyc.size() - br); end
    checks++; if (dut.occ !== 2'd2)   begin failures++; $display("FAIL stall_occ got=%0d exp=2", dut.occ); end
    checks++; if (OutData !== 8'h31)  begin failures++; $display("FAIL stall_head got=%h exp=31", OutData); end
    checks++; if (Overrun !== 1'b0)   begin failures++; $display("FAIL stall_overrun got=%b exp=0", Overrun); end
    OutReady = 1'b1;
    repeat (16) @(negedge Clk);
    checks++; if (got_data.size() - bh !== 8) begin failures++; $display("FAIL stall_words got=%0d exp=8", got_data.size() - bh); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data.size() - bh != 8 || got_data[bh+i] !== 8'h31 + 8'(i) ||
          (i > 0 && hs_cyc[bh+i] - hs_cyc[bh+i-1] > 2)) begin
        failures++; $display("FAIL stall_order idx=%0d exp_data=%h", i, 8'h31 + 8'(i));
      end
    end
  endtask

  task automatic test_single();
    int br, bh;
    OutReady = 1'b1; PktLen = 8'd0; Enable = 1'b1;
    do_reset();
    br = rd_cyc.size(); bh = got_data.size();
    preload(8'h41, 1);
    repeat (8) @(negedge Clk);
    checks++; if (rd_cyc.size() - br !== 1) begin failures++; $display("FAIL single_reads got=%0d exp=1", rd_cyc.size() - br); end
    checks++; if (rwe !== 0)  begin failures++; $display("FAIL single_read_while_empty got=%0d exp=0", rwe); end
    checks++; if (xcnt !== 0) begin failures++; $display("FAIL single_flag_x got=%0d exp=0", xcnt); end
    checks++;
    if (got_data.size() - bh != 1 || got_data[bh] !== 8'h41) begin
      failures++; $display("FAIL single_word count=%0d exp_data=41", got_data.size() - bh);
    end
  endtask

  task automatic test_overrun();
    int bh;
    OutReady = 1'b1; Enable = 1'b1;
    do_reset();
    bh = got_data.size();
    repeat (2) @(negedge Clk);
    inj_data = 8'hAA; inj_valid = 1'b1;
    @(negedge Clk);
    inj_valid = 1'b0;
    checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", Overrun); end
    repeat (3) @(negedge Clk);
    checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", Overrun); end
    checks++; if (OutValid !== 1'b0 || got_data.size() != bh) begin
      failures++; $display("FAIL overrun_dropped outvalid=%b words=%0d exp=0", OutValid, got_data.size() - bh);
    end
    do_reset();
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL overrun_cleared got=%b exp=0", Overrun); end
  endtask

  task automatic test_reset_mid();
    int bh, t;
    logic [5:0] exp_last;
    exp_last = 6'b100100;
    OutReady = 1'b1; PktLen = 8'd3; Enable = 1'b1;
    do_reset();
    bh = got_data.size();
    preload(8'h51, 12);
    t = 0;
    while (got_data.size() - bh < 4 && t < 20) begin @(negedge Clk); t++; end
    checks++; if (t >= 20 || Busy !== 1'b1) begin failures++; $display("FAIL midreset_setup t=%0d busy=%b", t, Busy); end
    do_reset();
    inj_data = 8'hEE; inj_valid = 1'b1;
    checks++; if (OutValid !== 1'b0)   begin failures++; $display("FAIL midreset_outvalid got=%b exp=0", OutValid); end
    checks++; if (Busy !== 1'b0)       begin failures++; $display("FAIL midreset_busy got=%b exp=0", Busy); end
    checks++; if (WordCount !== 16'd0) begin failures++; $display("FAIL midreset_wordcount got=%0d exp=0", WordCount); end
    @(negedge Clk);
    inj_valid = 1'b0;
    checks++; if (Overrun !== 1'b0 || OutValid !== 1'b0) begin
      failures++; $display("FAIL midreset_stale_valid overrun=%b outvalid=%b exp=0", Overrun, OutValid);
    end
    bh = got_data.size();
    preload(8'h61, 6);
    repeat (14) @(negedge Clk);
    checks++; if (WordCount !== 16'd6) begin failures++; $display("FAIL midreset_post_count got=%0d exp=6", WordCount); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_data.size() - bh != 6 || got_data[bh+i] !== 8'h61 + 8'(i) || got_last[bh+i] !== exp_last[i]) begin
        failures++; $display("FAIL midreset_post_word idx=%0d exp_last=%b", i, exp_last[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_packet(1'b0);
    test_packet(1'b1);
    test_stall();
    test_single();
    test_overrun();
    test_reset_mid();
    checks++; if (rwe !== 0) begin failures++; $display("FAIL global_read_while_empty got=%0d exp=0", rwe); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
